// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and W variants.
// One quotient bit per clock; divide-by-zero and signed overflow finish in one cycle.
module iter_divider #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic             word,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned SHW = WIDTH - 32;
  localparam bit          HAS_W = (WIDTH == 64);
  localparam logic [WIDTH-1:0] MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_W = ~WIDTH'(32'h7FFF_FFFF);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r, is_rem, word_q;

  logic             accept, word_eff, sgn, a_neg, b_neg, dz, ovf;
  logic [WIDTH-1:0] ea, eb, mag_a, mag_b, spec_sel;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin, fin;

  function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
    return WIDTH'(signed'(x));
  endfunction

  assign accept = valid && ready && !flush;

  // Operand preprocessing and single-cycle special results
  always_comb begin
    word_eff = HAS_W && word;
    sgn      = ~op[0];
    ea       = a;
    eb       = b;
    if (word_eff) begin
      ea = sgn ? sext32(a[31:0]) : WIDTH'(a[31:0]);
      eb = sgn ? sext32(b[31:0]) : WIDTH'(b[31:0]);
    end
    a_neg    = sgn && ea[WIDTH-1];
    b_neg    = sgn && eb[WIDTH-1];
    mag_a    = a_neg ? -ea : ea;
    mag_b    = b_neg ? -eb : eb;
    dz       = (eb == '0);
    ovf      = sgn && (ea == (word_eff ? MIN_W : MIN_D)) && (eb == '1);
    spec_sel = op[1] ? (dz ? ea : '0) : (dz ? '1 : ea);
    if (word_eff) spec_sel = sext32(spec_sel[31:0]);
  end

  // One restoring step plus sign fix-up of the would-be final values
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    rem_nx  = shifted[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end
    q_fin = neg_q ? -quo_nx : quo_nx;
    r_fin = neg_r ? -rem_nx : rem_nx;
    fin   = is_rem ? r_fin : q_fin;
    if (word_q) fin = sext32(fin[31:0]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (dz || ovf) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      ready <= (state_nx == IDLE);
      done  <= (state_nx == DONE);
    end
  end

  // Word mode pre-shifts the dividend so 32 steps leave the quotient in the low half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      word_q <= 1'b0;
      result <= '0;
    end else if (accept) begin
      cnt    <= (dz || ovf) ? '0 : (word_eff ? CW'(32) : CW'(WIDTH));
      rem    <= '0;
      quo    <= word_eff ? (mag_a << SHW) : mag_a;
      dvs    <= mag_b;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      is_rem <= op[1];
      word_q <= word_eff;
      if (dz || ovf) result <= spec_sel;
    end else if (state == CALC && !flush) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) result <= fin;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (WIDTH=64): hand-computed results, latencies,
// flush and asynchronous reset behaviour.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [1:0]  op;
  logic        word;
  logic [63:0] a, b;
  logic        flush;
  logic        done;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  iter_divider #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .op(op),
    .word(word), .a(a), .b(b), .flush(flush), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, measure edges from acceptance to done, check result and handshake
  task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp_r, input int exp_lat);
    int n;
    bit busy_ok;
    @(negedge clk);
    op = o; word = w; a = av; b = bv; valid = 1'b1;
    chk({tag, "_ready_idle"}, 64'(ready), 64'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 200) begin
      if (ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_busy_ready_low"}, 64'(busy_ok), 64'd1);
    chk({tag, "_ready_with_done"}, 64'(ready), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1; valid = 1'b0; op = 2'b00; word = 1'b0; a = '0; b = '0; flush = 1'b0;
    #12;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op("div_m20_3",   DIV,  1'b0, -64'sd20, 64'd3,   64'hFFFF_FFFF_FFFF_FFFA, 64);
    run_op("rem_m20_3",   REM,  1'b0, -64'sd20, 64'd3,   64'hFFFF_FFFF_FFFF_FFFE, 64);
    run_op("rem_20_m3",   REM,  1'b0, 64'd20,   -64'sd3, 64'd2, 64);
    run_op("remu_20_3",   REMU, 1'b0, 64'd20,   64'd3,   64'd2, 64);
    run_op("divu_dz",     DIVU, 1'b0, 64'h1234, 64'd0,   64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu_dz",     REMU, 1'b0, 64'h1234, 64'd0,   64'h1234, 0);
    run_op("div_ovf",     DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 0);
    run_op("rem_ovf",     REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 0);
    run_op("divuw_1",     DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1,
           64'hFFFF_FFFF_8000_0000, 32);
    run_op("divw_m8_2",   DIV,  1'b1, 64'h0000_0000_FFFF_FFF8, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFC, 32);
    run_op("remw_m7_2",   REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
           64'hFFFF_FFFF_FFFF_FFFF, 32);
    run_op("divw_ovf",    DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op("remuw_dz",    REMU, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_8000_0000, 0);

    // Flush on the 10th CALC cycle
    @(negedge clk);
    op = DIVU; word = 1'b0; a = 64'd1000; b = 64'd3; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_pre_ready", 64'(ready), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_result_kept", result, 64'hFFFF_FFFF_8000_0000);
    saw_done = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("flush_no_late_done", 64'(saw_done), 64'd0);

    run_op("divu_100_7",  DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 64);

    // Flush in the acceptance cycle blocks a would-be single-cycle op
    @(negedge clk);
    op = DIVU; word = 1'b0; a = 64'd5; b = 64'd0; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush_accept_done", 64'(done), 64'd0);
    chk("flush_accept_ready", 64'(ready), 64'd1);
    chk("flush_accept_result", result, 64'd14);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = DIVU; word = 1'b0; a = 64'd100; b = 64'd7; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_calc_busy", 64'(ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_ready", 64'(ready), 64'd1);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_result", result, 64'd0);
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("post_rst_no_done", 64'(saw_done), 64'd0);
    chk("post_rst_ready", 64'(ready), 64'd1);

    run_op("div_7_m2",    DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
